// File: rtl/lfst.sv
// ----------------------------------------------------------------------------
// lfst : Last Fetched Store Table for store-set memory dependence prediction.
//
// Sits in rename after the SSIT lookup. Each of the 2**SSID_W entries holds
// the ROB tag of the youngest renamed, not yet issued store of that store set.
// Every active load/store in a 4-wide rename group gets the producer-store tag
// it must wait on, and every active store becomes the new last store of its set.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   flush_i               invalidate all entries, discard the current group
//   ren_vld_i             rename group valid (4 slots)
//   instN_ssid_i/_vld_i   slot N store set ID and its valid (N=0..3)
//   instN_is_st_i/_ld_i   slot N is a store / load
//   instN_tag_i           slot N ROB tag
//   st_iss_vld_i/_ssid_i/_tag_i  store issued this cycle (clears its entry)
//   out_vld_o             registered group result valid (latency 1)
//   instN_dep_vld_o/_tag_o  slot N must wait on store with this ROB tag
// ----------------------------------------------------------------------------
module lfst #(
    parameter int unsigned SSID_W = 7,
    parameter int unsigned TAG_W  = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              ren_vld_i,
    input  logic [SSID_W-1:0] inst0_ssid_i,
    input  logic              inst0_ssid_vld_i,
    input  logic              inst0_is_st_i,
    input  logic              inst0_is_ld_i,
    input  logic [TAG_W-1:0]  inst0_tag_i,
    input  logic [SSID_W-1:0] inst1_ssid_i,
    input  logic              inst1_ssid_vld_i,
    input  logic              inst1_is_st_i,
    input  logic              inst1_is_ld_i,
    input  logic [TAG_W-1:0]  inst1_tag_i,
    input  logic [SSID_W-1:0] inst2_ssid_i,
    input  logic              inst2_ssid_vld_i,
    input  logic              inst2_is_st_i,
    input  logic              inst2_is_ld_i,
    input  logic [TAG_W-1:0]  inst2_tag_i,
    input  logic [SSID_W-1:0] inst3_ssid_i,
    input  logic              inst3_ssid_vld_i,
    input  logic              inst3_is_st_i,
    input  logic              inst3_is_ld_i,
    input  logic [TAG_W-1:0]  inst3_tag_i,
    input  logic              st_iss_vld_i,
    input  logic [SSID_W-1:0] st_iss_ssid_i,
    input  logic [TAG_W-1:0]  st_iss_tag_i,
    output logic              out_vld_o,
    output logic              inst0_dep_vld_o,
    output logic [TAG_W-1:0]  inst0_dep_tag_o,
    output logic              inst1_dep_vld_o,
    output logic [TAG_W-1:0]  inst1_dep_tag_o,
    output logic              inst2_dep_vld_o,
    output logic [TAG_W-1:0]  inst2_dep_tag_o,
    output logic              inst3_dep_vld_o,
    output logic [TAG_W-1:0]  inst3_dep_tag_o
);

    localparam int unsigned DEPTH = 1 << SSID_W;
    localparam int unsigned NSLOT = 4;

    // Table storage: valid bits are reset, tags only matter when valid.
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] tag_d [DEPTH];

    // Registered outputs.
    logic             out_vld_q;
    logic [NSLOT-1:0] dep_vld_q, dep_vld_d;
    logic [TAG_W-1:0] dep_tag_q [NSLOT];
    logic [TAG_W-1:0] dep_tag_d [NSLOT];

    // Slot inputs gathered into arrays for loop-based logic.
    logic [SSID_W-1:0] ssid_c [NSLOT];
    logic [TAG_W-1:0]  itag_c [NSLOT];
    logic [NSLOT-1:0]  ssid_vld_c, is_st_c, is_ld_c, act_c, st_act_c;
    logic              iss_hit_c;

    assign ssid_c[0] = inst0_ssid_i;
    assign ssid_c[1] = inst1_ssid_i;
    assign ssid_c[2] = inst2_ssid_i;
    assign ssid_c[3] = inst3_ssid_i;
    assign itag_c[0] = inst0_tag_i;
    assign itag_c[1] = inst1_tag_i;
    assign itag_c[2] = inst2_tag_i;
    assign itag_c[3] = inst3_tag_i;
    assign ssid_vld_c = {inst3_ssid_vld_i, inst2_ssid_vld_i, inst1_ssid_vld_i, inst0_ssid_vld_i};
    assign is_st_c    = {inst3_is_st_i, inst2_is_st_i, inst1_is_st_i, inst0_is_st_i};
    assign is_ld_c    = {inst3_is_ld_i, inst2_is_ld_i, inst1_is_ld_i, inst0_is_ld_i};

    // Slot activity; stores only write when not flushed.
    assign act_c    = {NSLOT{ren_vld_i}} & ssid_vld_c & (is_st_c | is_ld_c);
    assign st_act_c = act_c & is_st_c & {NSLOT{~flush_i}};

    // Issuing store still owns its entry (5th read port).
    assign iss_hit_c = st_iss_vld_i && vld_q[st_iss_ssid_i] && (tag_q[st_iss_ssid_i] == st_iss_tag_i);

    // Dependence lookup: table first, then nearest earlier in-group store overrides.
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            dep_vld_d[k] = 1'b0;
            dep_tag_d[k] = '0;
            if (vld_q[ssid_c[k]] &&
                !(st_iss_vld_i && ssid_c[k] == st_iss_ssid_i && tag_q[ssid_c[k]] == st_iss_tag_i)) begin
                dep_vld_d[k] = 1'b1;
                dep_tag_d[k] = tag_q[ssid_c[k]];
            end
            for (int j = 0; j < NSLOT; j++) begin
                if (j < k && act_c[j] && is_st_c[j] && ssid_c[j] == ssid_c[k]) begin
                    dep_vld_d[k] = 1'b1;
                    dep_tag_d[k] = itag_c[j];
                end
            end
            if (!act_c[k] || flush_i) begin
                dep_vld_d[k] = 1'b0;
                dep_tag_d[k] = '0;
            end
        end
    end

    // Table update: issue clear, then rename writes (higher slot wins), flush last.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        if (iss_hit_c) begin
            vld_d[st_iss_ssid_i] = 1'b0;
        end
        for (int k = 0; k < NSLOT; k++) begin
            if (st_act_c[k]) begin
                vld_d[ssid_c[k]] = 1'b1;
                tag_d[ssid_c[k]] = itag_c[k];
            end
        end
        if (flush_i) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q     <= '0;
            out_vld_q <= 1'b0;
            dep_vld_q <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                dep_tag_q[k] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            out_vld_q <= ren_vld_i & ~flush_i;
            dep_vld_q <= dep_vld_d;
            dep_tag_q <= dep_tag_d;
        end
    end

    // Tag array needs no reset; gated by valid bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tag_q <= tag_d;
        end
    end

    assign out_vld_o       = out_vld_q;
    assign inst0_dep_vld_o = dep_vld_q[0];
    assign inst1_dep_vld_o = dep_vld_q[1];
    assign inst2_dep_vld_o = dep_vld_q[2];
    assign inst3_dep_vld_o = dep_vld_q[3];
    assign inst0_dep_tag_o = dep_tag_q[0];
    assign inst1_dep_tag_o = dep_tag_q[1];
    assign inst2_dep_tag_o = dep_tag_q[2];
    assign inst3_dep_tag_o = dep_tag_q[3];

endmodule

// File: tb/tb_lfst.sv
// ----------------------------------------------------------------------------
// tb_lfst : directed self-checking bench for lfst.
// ----------------------------------------------------------------------------
module tb_lfst;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush_i;
    logic       ren_vld_i;
    logic [6:0] ssid    [4];
    logic [3:0] ssid_vld;
    logic [3:0] is_st;
    logic [3:0] is_ld;
    logic [6:0] tag     [4];
    logic       st_iss_vld_i;
    logic [6:0] st_iss_ssid_i;
    logic [6:0] st_iss_tag_i;
    logic       out_vld_o;
    logic [3:0] dep_vld;
    logic [6:0] dep_tag [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    lfst #(.SSID_W(7), .TAG_W(7)) dut (
        .clock            (clock),
        .reset            (reset),
        .flush_i          (flush_i),
        .ren_vld_i        (ren_vld_i),
        .inst0_ssid_i     (ssid[0]),
        .inst0_ssid_vld_i (ssid_vld[0]),
        .inst0_is_st_i    (is_st[0]),
        .inst0_is_ld_i    (is_ld[0]),
        .inst0_tag_i      (tag[0]),
        .inst1_ssid_i     (ssid[1]),
        .inst1_ssid_vld_i (ssid_vld[1]),
        .inst1_is_st_i    (is_st[1]),
        .inst1_is_ld_i    (is_ld[1]),
        .inst1_tag_i      (tag[1]),
        .inst2_ssid_i     (ssid[2]),
        .inst2_ssid_vld_i (ssid_vld[2]),
        .inst2_is_st_i    (is_st[2]),
        .inst2_is_ld_i    (is_ld[2]),
        .inst2_tag_i      (tag[2]),
        .inst3_ssid_i     (ssid[3]),
        .inst3_ssid_vld_i (ssid_vld[3]),
        .inst3_is_st_i    (is_st[3]),
        .inst3_is_ld_i    (is_ld[3]),
        .inst3_tag_i      (tag[3]),
        .st_iss_vld_i     (st_iss_vld_i),
        .st_iss_ssid_i    (st_iss_ssid_i),
        .st_iss_tag_i     (st_iss_tag_i),
        .out_vld_o        (out_vld_o),
        .inst0_dep_vld_o  (dep_vld[0]),
        .inst0_dep_tag_o  (dep_tag[0]),
        .inst1_dep_vld_o  (dep_vld[1]),
        .inst1_dep_tag_o  (dep_tag[1]),
        .inst2_dep_vld_o  (dep_vld[2]),
        .inst2_dep_tag_o  (dep_tag[2]),
        .inst3_dep_vld_o  (dep_vld[3]),
        .inst3_dep_tag_o  (dep_tag[3])
    );

    task automatic clear_inputs();
        flush_i       = 1'b0;
        ren_vld_i     = 1'b0;
        ssid_vld      = '0;
        is_st         = '0;
        is_ld         = '0;
        st_iss_vld_i  = 1'b0;
        st_iss_ssid_i = '0;
        st_iss_tag_i  = '0;
        for (int i = 0; i < 4; i++) begin
            ssid[i] = '0;
            tag[i]  = '0;
        end
    endtask

    // Place a load (st=0) or store (st=1) into slot n; the group becomes valid.
    task automatic slot(input int n, input logic st, input logic [6:0] s, input logic [6:0] t);
        ren_vld_i   = 1'b1;
        ssid_vld[n] = 1'b1;
        is_st[n]    = st;
        is_ld[n]    = ~st;
        ssid[n]     = s;
        tag[n]      = t;
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic chk_dep(input string name, input int n, input logic v, input logic [6:0] t);
        chk({name, "_vld"}, 32'(dep_vld[n]), 32'(v));
        chk({name, "_tag"}, 32'(dep_tag[n]), 32'(t));
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        chk("rst_out_vld", 32'(out_vld_o), 32'h0);
        for (int i = 0; i < 4; i++) chk_dep("rst_dep", i, 1'b0, 7'h0);
        reset = 1'b0;

        // Load on an empty set: no dependence.
        slot(0, 1'b0, 7'd5, 7'h01);
        cyc();
        chk("ld_empty_out_vld", 32'(out_vld_o), 32'h1);
        chk_dep("ld_empty", 0, 1'b0, 7'h0);
        clear_inputs();

        // Store ss5 t=0x12, then a load on ss5 depends on it.
        slot(0, 1'b1, 7'd5, 7'h12);
        cyc();
        chk_dep("st5", 0, 1'b0, 7'h0);
        clear_inputs();
        slot(0, 1'b0, 7'd5, 7'h13);
        cyc();
        chk_dep("ld5", 0, 1'b1, 7'h12);
        clear_inputs();

        // Idle cycle: out_vld drops.
        cyc();
        chk("idle_out_vld", 32'(out_vld_o), 32'h0);

        // Intra-group chain on ss3; slot2 carries an ssid_vld=0 load.
        slot(0, 1'b1, 7'd3, 7'h04);
        slot(1, 1'b1, 7'd3, 7'h05);
        slot(2, 1'b0, 7'd3, 7'h06);
        ssid_vld[2] = 1'b0;
        slot(3, 1'b0, 7'd3, 7'h07);
        cyc();
        chk_dep("grp_s0", 0, 1'b0, 7'h0);
        chk_dep("grp_s1", 1, 1'b1, 7'h04);
        chk_dep("grp_s2", 2, 1'b0, 7'h0);
        chk_dep("grp_s3", 3, 1'b1, 7'h05);
        clear_inputs();
        slot(0, 1'b0, 7'd3, 7'h08);
        cyc();
        chk_dep("ld3_after", 0, 1'b1, 7'h05);
        clear_inputs();

        // Issue bypass on ss9 with matching tag; entry is then cleared.
        slot(0, 1'b1, 7'd9, 7'h20);
        cyc();
        clear_inputs();
        slot(0, 1'b0, 7'd9, 7'h22);
        st_iss_vld_i = 1'b1; st_iss_ssid_i = 7'd9; st_iss_tag_i = 7'h20;
        cyc();
        chk_dep("byp_match", 0, 1'b0, 7'h0);
        clear_inputs();
        slot(0, 1'b0, 7'd9, 7'h23);
        cyc();
        chk_dep("byp_cleared", 0, 1'b0, 7'h0);
        clear_inputs();

        // Issue with a different tag: no bypass, entry keeps 0x20.
        slot(0, 1'b1, 7'd9, 7'h20);
        cyc();
        clear_inputs();
        slot(0, 1'b0, 7'd9, 7'h24);
        st_iss_vld_i = 1'b1; st_iss_ssid_i = 7'd9; st_iss_tag_i = 7'h21;
        cyc();
        chk_dep("byp_mismatch", 0, 1'b1, 7'h20);
        clear_inputs();
        slot(0, 1'b0, 7'd9, 7'h25);
        cyc();
        chk_dep("byp_kept", 0, 1'b1, 7'h20);
        clear_inputs();

        // Rename write wins over issue clear of the older store on ss7.
        slot(0, 1'b1, 7'd7, 7'h2F);
        cyc();
        clear_inputs();
        slot(0, 1'b1, 7'd7, 7'h30);
        st_iss_vld_i = 1'b1; st_iss_ssid_i = 7'd7; st_iss_tag_i = 7'h2F;
        cyc();
        chk_dep("st7_byp", 0, 1'b0, 7'h0);
        clear_inputs();
        slot(0, 1'b0, 7'd7, 7'h31);
        cyc();
        chk_dep("ld7_new", 0, 1'b1, 7'h30);
        clear_inputs();

        // Fill ss1/ss2, flush with a valid group, then loads see nothing.
        slot(0, 1'b1, 7'd1, 7'h41);
        slot(1, 1'b1, 7'd2, 7'h42);
        cyc();
        clear_inputs();
        slot(0, 1'b0, 7'd1, 7'h43);
        slot(1, 1'b0, 7'd2, 7'h44);
        flush_i = 1'b1;
        cyc();
        chk("flush_out_vld", 32'(out_vld_o), 32'h0);
        chk_dep("flush_s0", 0, 1'b0, 7'h0);
        chk_dep("flush_s1", 1, 1'b0, 7'h0);
        flush_i = 1'b0;
        cyc();
        chk("post_flush_out_vld", 32'(out_vld_o), 32'h1);
        chk_dep("post_flush_s0", 0, 1'b0, 7'h0);
        chk_dep("post_flush_s1", 1, 1'b0, 7'h0);
        clear_inputs();

        // Refill ss1, then the same loads under reset: all outputs 0, table cleared.
        slot(0, 1'b1, 7'd1, 7'h45);
        cyc();
        clear_inputs();
        slot(0, 1'b0, 7'd1, 7'h46);
        slot(1, 1'b0, 7'd2, 7'h47);
        reset = 1'b1;
        cyc();
        chk("rst2_out_vld", 32'(out_vld_o), 32'h0);
        chk_dep("rst2_s0", 0, 1'b0, 7'h0);
        chk_dep("rst2_s1", 1, 1'b0, 7'h0);
        reset = 1'b0;
        cyc();
        chk("post_rst_out_vld", 32'(out_vld_o), 32'h1);
        chk_dep("post_rst_s0", 0, 1'b0, 7'h0);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
